// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch unit: FSM states, next-PC select codes, NOP.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;
    localparam logic [1:0] PCSRC_HOLD   = 2'b11;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: 4:1 pick of the candidates, jalr LSB clear, and a flag
// raised when the chosen address is not word aligned.
module pc_next_mux
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      pcsrc_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic [XLEN-1:0] pc_target_i,
    input  logic [XLEN-1:0] alu_result_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            misalign_o
);

    // bit 0 of the jalr target is discarded by definition
    logic unused_alu_lsb;
    assign unused_alu_lsb = alu_result_i[0];

    // Select the candidate; hold re-presents the current PC for a refetch.
    always_comb begin
        next_pc_o = pc_plus4_i;
        unique case (pcsrc_i)
            PCSRC_PLUS4:  next_pc_o = pc_plus4_i;
            PCSRC_TARGET: next_pc_o = pc_target_i;
            PCSRC_JALR:   next_pc_o = {alu_result_i[XLEN-1:1], 1'b0};
            PCSRC_HOLD:   next_pc_o = pc_i;
            default:      next_pc_o = pc_plus4_i;
        endcase
    end

    assign misalign_o = (next_pc_o[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC, fetch handshake FSM, instruction latch and retire counter.
// One instruction is fetched (FETCH) then presented to the datapath (EXEC);
// a misaligned next PC parks the unit in HALT until reset.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] PCPlus4,
    input  logic [XLEN-1:0] PCTarget,
    input  logic [XLEN-1:0] ALUResult,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_valid,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] Instr,
    output logic            instr_valid,
    output logic            misalign,
    output logic [31:0]     instret
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic            req_q;
    logic            vld_q;
    logic            misalign_q;
    logic [31:0]     instret_q;

    logic [XLEN-1:0] next_pc_d;
    logic            next_mis_d;
    logic [31:0]     instret_d;

    pc_next_mux #(.XLEN(XLEN)) u_next_mux (
        .pcsrc_i      (PCSrc),
        .pc_i         (pc_q),
        .pc_plus4_i   (PCPlus4),
        .pc_target_i  (PCTarget),
        .alu_result_i (ALUResult),
        .next_pc_o    (next_pc_d),
        .misalign_o   (next_mis_d)
    );

    assign instret_d = instret_q + 32'd1;

    // Fetch/exec FSM with registered handshake outputs; PC, Instr and the
    // retire counter only move on the FSM transitions that own them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= NOP;
            req_q      <= 1'b1;
            vld_q      <= 1'b0;
            misalign_q <= 1'b0;
            instret_q  <= '0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_valid) begin
                        instr_q <= imem_rdata;
                        state_q <= EXEC;
                        req_q   <= 1'b0;
                        vld_q   <= 1'b1;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        vld_q <= 1'b0;
                        if (!next_mis_d) begin
                            pc_q      <= next_pc_d;
                            instret_q <= instret_d;
                            state_q   <= FETCH;
                            req_q     <= 1'b1;
                        end else begin
                            misalign_q <= 1'b1;
                            state_q    <= HALT;
                        end
                    end
                end
                HALT: begin
                    req_q <= 1'b0;
                    vld_q <= 1'b0;
                end
                default: begin
                    state_q <= HALT;
                    req_q   <= 1'b0;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign Instr       = instr_q;
    assign instr_valid = vld_q;
    assign misalign    = misalign_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  PCSrc;
    logic [31:0] PCPlus4;
    logic [31:0] PCTarget;
    logic [31:0] ALUResult;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic        instr_valid;
    logic        misalign;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    // stands in for the upstream PC+4 adder
    assign PCPlus4 = PC + 32'd4;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PCSrc      (PCSrc),
        .PCPlus4    (PCPlus4),
        .PCTarget   (PCTarget),
        .ALUResult  (ALUResult),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .PC         (PC),
        .Instr      (Instr),
        .instr_valid(instr_valid),
        .misalign   (misalign),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        PCSrc      = 2'b00;
        PCTarget   = '0;
        ALUResult  = '0;
        stall      = 1'b0;
        imem_rdata = 32'h0000_0013;
        imem_valid = 1'b1;

        // reset state
        step(); step();
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instr, 32'h0000_0013);
        chk("rst_ivalid", {31'b0, instr_valid}, 32'h0);
        chk("rst_misalign", {31'b0, misalign}, 32'h0);
        chk("rst_instret", instret, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_req", {31'b0, imem_req}, 32'h1);
        chk("rel_addr", imem_addr, 32'h0);

        // 1: sequential stream, two cycles per instruction
        for (int i = 0; i < 3; i++) begin
            step();
            chk("seq_exec_valid", {31'b0, instr_valid}, 32'h1);
            chk("seq_exec_pc", PC, 32'(i * 4));
            step();
            chk("seq_fetch_pc", imem_addr, 32'(i * 4 + 4));
            chk("seq_instret", instret, 32'(i + 1));
        end
        // PC=0xC in FETCH; advance to EXEC at 0x10
        step(); step(); step();
        chk("exec_at_10", PC, 32'h10);

        // 2: branch target
        PCSrc = 2'b01; PCTarget = 32'h40;
        step();
        chk("br_addr", imem_addr, 32'h40);
        chk("br_req", {31'b0, imem_req}, 32'h1);
        chk("br_instret", instret, 32'd5);

        // 4: wait-stated fetch, then stall in EXEC
        imem_valid = 1'b0; PCSrc = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_req", {31'b0, imem_req}, 32'h1);
            chk("wait_addr", imem_addr, 32'h40);
            chk("wait_ivalid", {31'b0, instr_valid}, 32'h0);
        end
        imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        chk("wait_instr", Instr, 32'hDEAD_BEEF);
        imem_valid = 1'b0; stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_pc", PC, 32'h40);
            chk("stall_instr", Instr, 32'hDEAD_BEEF);
            chk("stall_instret", instret, 32'd5);
            chk("stall_ivalid", {31'b0, instr_valid}, 32'h1);
        end
        stall = 1'b0;
        step();
        chk("unstall_pc", PC, 32'h44);
        chk("unstall_instret", instret, 32'd6);

        // 3: jalr LSB clear, then misaligned jalr halts
        imem_valid = 1'b1; imem_rdata = 32'h0000_0013;
        step();
        PCSrc = 2'b10; ALUResult = 32'h0000_0105;
        step();
        chk("jalr_pc", PC, 32'h104);
        chk("jalr_instret", instret, 32'd7);
        step();
        ALUResult = 32'h0000_0106;
        step();
        chk("mis_flag", {31'b0, misalign}, 32'h1);
        chk("mis_pc", PC, 32'h104);
        chk("mis_instret", instret, 32'd7);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_req", {31'b0, imem_req}, 32'h0);
            chk("halt_ivalid", {31'b0, instr_valid}, 32'h0);
            chk("halt_pc", PC, 32'h104);
        end

        // 5: async reset out of HALT, then reset mid-fetch at 0x20
        rst_n = 1'b0;
        #1;
        chk("async_pc", PC, 32'h0);
        chk("async_misalign", {31'b0, misalign}, 32'h0);
        step();
        rst_n = 1'b1; PCSrc = 2'b00;
        for (int i = 0; i < 16; i++) step();
        imem_valid = 1'b0;
        #1;
        chk("mid_addr", imem_addr, 32'h20);
        chk("mid_instret", instret, 32'd8);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", PC, 32'h0);
        chk("mid_rst_instret", instret, 32'h0);
        imem_valid = 1'b1; imem_rdata = 32'h0BAD_C0DE;
        step(); step();
        chk("stale_ivalid", {31'b0, instr_valid}, 32'h0);
        chk("stale_instr", Instr, 32'h0000_0013);
        imem_valid = 1'b0; rst_n = 1'b1;
        step();
        chk("post_rst_req", {31'b0, imem_req}, 32'h1);
        chk("post_rst_ivalid", {31'b0, instr_valid}, 32'h0);

        // 6: counter and PC wrap
        imem_valid = 1'b1; imem_rdata = 32'h0000_0013;
        step();
        PCSrc = 2'b01; PCTarget = 32'hFFFF_FFFC;
        step();
        chk("top_pc", PC, 32'hFFFF_FFFC);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        step();
        PCSrc = 2'b00;
        step();
        chk("wrap_pc", PC, 32'h0);
        chk("wrap_instret", instret, 32'h0);
        chk("wrap_misalign", {31'b0, misalign}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
